fft_n_point_seq: RTL and testbench
==================================

Name: fft_n_point_seq

Overview:
- Iterative radix-2 decimation-in-time FFT on a packed buffer of BUFFER_SIZE real, signed, fixed-width samples.
- Produces packed complex bins (real and imaginary buffers) in natural order.
- Twiddle factors are fixed-point constants scaled by NO_FLOAT_MULT and held in an internal ROM, the twiddle coordinator.
- Sits between the sample-capture buffer and the spectral post-processing stage.

Parameters:
- BUFFER_SIZE, 16, number of points N; power of two, >= 2.
- SAMPLE_SIZE, 32, width of each input sample and each output component (signed).
- TWIDDLE_SIZE, 16, signed width of each twiddle component.
- NO_FLOAT_MULT, 256, fixed-point scale of twiddles; any positive integer, need not be a power of two.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset.
- start, input, 1, request a transform of input_real.
- input_real, input, BUFFER_SIZE*SAMPLE_SIZE, sample j at bits [j*SAMPLE_SIZE +: SAMPLE_SIZE].
- busy, output, 1, transform in progress.
- done, output, 1, one-cycle pulse when outputs are updated.
- output_real, output, BUFFER_SIZE*SAMPLE_SIZE, real part of bin k at [k*SAMPLE_SIZE +: SAMPLE_SIZE].
- output_imag, output, BUFFER_SIZE*SAMPLE_SIZE, imaginary part of bin k, same packing.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low. The clock is clk and the reset is rst_n.
- Reset values: busy=0, done=0, output_real=0, output_imag=0, working memory cleared, state IDLE. Reset mid-transform aborts it and produces no done.
- States:
  - IDLE: on a clk edge with start=1, capture input_real into working memory in bit-reversed index order (imag=0), set busy=1, go to COMPUTE.
  - COMPUTE: exactly one butterfly per cycle; stage s = 1..log2N, butterflies in ascending index order within each stage. After the (N/2)*log2N-th butterfly, go to FINISH.
  - FINISH: copy working memory to output_real/output_imag; done=1 for this one cycle; busy=0; return to IDLE.
- Latency: start sampled at edge t gives done high after edge t + (N/2)*log2N + 1. For N=16 that is 33 cycles.
- start while busy=1 is ignored. start may be held high; a new transform begins on the first IDLE edge. done and start in the same cycle: the new capture proceeds.
- Outputs hold their value between done pulses.
- Twiddle ROM: for k = 0..N/2-1, W_k = round(NO_FLOAT_MULT*cos(2*pi*k/N)) - j*round(NO_FLOAT_MULT*sin(2*pi*k/N)). Rounding is to nearest, ties away from zero. The ROM is built at elaboration and has no runtime ports.
- Butterfly for (a, b, twiddle W):
  - t = (b*W) / NO_FLOAT_MULT, computed per component on full-precision products (width SAMPLE_SIZE+TWIDDLE_SIZE+1).
  - Division is signed and truncates toward zero.
  - a' = a + t, b' = a - t.
- Results are truncated to SAMPLE_SIZE bits (two's-complement wrap, no saturation). No per-stage scaling unless the optional feature is enabled.

Optional Feature:
- Macro FFT_STAGE_SCALE_EN.
- Defined: every butterfly output is arithmetic-shifted right by 1 before storage, so final bins equal X[k]/N with floor per stage.
- Undefined: no scaling; bins equal the unnormalised DFT sum within fixed-point error.
- The test values below assume the macro is undefined.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 → busy=0, done=0, all outputs 0. Assert rst_n=0 at cycle 10 of a transform → no done; outputs 0; busy=0 the next cycle.
- Impulse, N=16: x[0]=100, others 0, pulse start → done exactly 33 cycles later; all 16 bins real=100, imag=0.
- DC: all samples 5 → bin0 = (80, 0); bins 1..15 = (0, 0) exactly.
- Alternating: x[n] = +10 (n even), -10 (n odd) → bin8 = (160, 0); all other bins (0, 0).
- Cosine: x[n] = round(100*cos(2*pi*n/16)) → bins 1 and 15 real within 800±16, imag within ±16; all other bins within ±16 per component. Negative sample values must be handled correctly.
- Handshake: pulse start, then pulse start again at cycle 5 while busy → exactly one done. A second start after done → second done 33 cycles later; outputs unchanged in between.

Source files
------------

// File: rtl/fft_n_point_seq.sv
// fft_n_point_seq: iterative radix-2 DIT FFT, one butterfly per clock, over a packed buffer of real samples.
//
// Ports:
//   clk         - system clock
//   rst_n       - synchronous active-low reset; aborts any transform in progress
//   start       - request a transform of input_real (ignored while busy)
//   input_real  - BUFFER_SIZE signed samples, sample j at [j*SAMPLE_SIZE +: SAMPLE_SIZE]
//   busy        - transform in progress
//   done        - one-cycle pulse when output_real/output_imag are updated
//   output_real - real part of bin k at [k*SAMPLE_SIZE +: SAMPLE_SIZE], natural order
//   output_imag - imaginary part of bin k, same packing
//
// Optional build macro FFT_STAGE_SCALE_EN: halve every butterfly output so bins come out as X[k]/N.
module fft_n_point_seq #(
    parameter int BUFFER_SIZE   = 16,
    parameter int SAMPLE_SIZE   = 32,
    parameter int TWIDDLE_SIZE  = 16,
    parameter int NO_FLOAT_MULT = 256
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  input_real,
    output logic                                busy,
    output logic                                done,
    output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  output_real,
    output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  output_imag
);
    localparam int LOG2N = $clog2(BUFFER_SIZE);
    localparam int P     = SAMPLE_SIZE + TWIDDLE_SIZE + 1;
    localparam logic [LOG2N-1:0] ONE  = LOG2N'(1);
    localparam logic [LOG2N-1:0] LMAX = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] HMAX = LOG2N'(BUFFER_SIZE / 2 - 1);
    localparam logic signed [P-1:0] MULT = P'(NO_FLOAT_MULT);
    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

    state_t state;
    logic signed [SAMPLE_SIZE-1:0]  mem_re [BUFFER_SIZE];
    logic signed [SAMPLE_SIZE-1:0]  mem_im [BUFFER_SIZE];
    logic signed [TWIDDLE_SIZE-1:0] rom_re [BUFFER_SIZE];
    logic signed [TWIDDLE_SIZE-1:0] rom_im [BUFFER_SIZE];
    logic [LOG2N-1:0] st, bf, half, pos, ia, ib, tk;
    logic signed [P-1:0] ar, ai, br, bi, wr, wi, tr, ti;
    logic signed [SAMPLE_SIZE-1:0] na_re, na_im, nb_re, nb_im;

    // Rounded-to-nearest (ties away from zero) twiddle component; im selects -sin.
    function automatic logic signed [TWIDDLE_SIZE-1:0] twiddle(input int k, input logic im);
        real a, v;
        int r;
        a = 2.0 * PI * real'(k) / real'(BUFFER_SIZE);
        v = real'(NO_FLOAT_MULT) * (im ? -$sin(a) : $cos(a));
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        return TWIDDLE_SIZE'(r);
    endfunction

    function automatic int rev(input int v);
        int r;
        r = 0;
        for (int b = 0; b < LOG2N; b++)
            r = r | (((v >> b) & 1) << (LOG2N - 1 - b));
        return r;
    endfunction

    // Constant ROM; only entries below N/2 are ever addressed.
    for (genvar k = 0; k < BUFFER_SIZE; k++) begin : g_rom
        assign rom_re[k] = twiddle(k, 1'b0);
        assign rom_im[k] = twiddle(k, 1'b1);
    end

    // Butterfly bf of stage st (0-based): span half, pair (ia, ib), twiddle index pos scaled to N.
    always_comb begin
        half = ONE << st;
        pos  = bf & (half - ONE);
        ia   = ((bf & ~(half - ONE)) << 1) | pos;
        ib   = ia | half;
        tk   = pos << (LMAX - st);
        ar   = P'(mem_re[ia]);
        ai   = P'(mem_im[ia]);
        br   = P'(mem_re[ib]);
        bi   = P'(mem_im[ib]);
        wr   = P'(rom_re[tk]);
        wi   = P'(rom_im[tk]);
        tr   = (br * wr - bi * wi) / MULT;
        ti   = (br * wi + bi * wr) / MULT;
`ifdef FFT_STAGE_SCALE_EN
        na_re = SAMPLE_SIZE'((ar + tr) >>> 1);
        na_im = SAMPLE_SIZE'((ai + ti) >>> 1);
        nb_re = SAMPLE_SIZE'((ar - tr) >>> 1);
        nb_im = SAMPLE_SIZE'((ai - ti) >>> 1);
`else
        na_re = SAMPLE_SIZE'(ar + tr);
        na_im = SAMPLE_SIZE'(ai + ti);
        nb_re = SAMPLE_SIZE'(ar - tr);
        nb_im = SAMPLE_SIZE'(ai - ti);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            st          <= '0;
            bf          <= '0;
            output_real <= '0;
            output_imag <= '0;
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < BUFFER_SIZE; i++) begin
                            mem_re[i] <= input_real[rev(i)*SAMPLE_SIZE +: SAMPLE_SIZE];
                            mem_im[i] <= '0;
                        end
                        busy  <= 1'b1;
                        st    <= '0;
                        bf    <= '0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    mem_re[ia] <= na_re;
                    mem_im[ia] <= na_im;
                    mem_re[ib] <= nb_re;
                    mem_im[ib] <= nb_im;
                    if (bf == HMAX) begin
                        bf <= '0;
                        if (st == LMAX)
                            state <= FINISH;
                        else
                            st <= st + ONE;
                    end else begin
                        bf <= bf + ONE;
                    end
                end
                FINISH: begin
                    for (int i = 0; i < BUFFER_SIZE; i++) begin
                        output_real[i*SAMPLE_SIZE +: SAMPLE_SIZE] <= mem_re[i];
                        output_imag[i*SAMPLE_SIZE +: SAMPLE_SIZE] <= mem_im[i];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_n_point_seq.sv
// tb_fft_n_point_seq: directed self-checking bench for fft_n_point_seq at N=16, 32-bit samples.
//
// Drives start/input_real/rst_n one time unit after each rising edge and samples there too.
module tb_fft_n_point_seq;
    localparam int N = 16;
    localparam int S = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [N*S-1:0] input_real = '0;
    logic busy, done;
    logic [N*S-1:0] output_real, output_imag;

    int checks = 0;
    int failures = 0;

    fft_n_point_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .input_real(input_real),
        .busy(busy),
        .done(done),
        .output_real(output_real),
        .output_imag(output_imag)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic chk_rng(input string tag, input longint observed, input longint lo, input longint hi);
        checks++;
        assert (observed >= lo && observed <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, observed, lo, hi);
        end
    endtask

    function automatic longint bin_re(input int k);
        logic signed [S-1:0] v;
        v = output_real[k*S +: S];
        return longint'(v);
    endfunction

    function automatic longint bin_im(input int k);
        logic signed [S-1:0] v;
        v = output_imag[k*S +: S];
        return longint'(v);
    endfunction

    task automatic load(input int x[N]);
        for (int i = 0; i < N; i++)
            input_real[i*S +: S] = x[i];
    endtask

    task automatic check_bins(input string tag, input int er[N], input int ei[N]);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s_re%0d", tag, k), bin_re(k), longint'(er[k]));
            chk($sformatf("%s_im%0d", tag, k), bin_im(k), longint'(ei[k]));
        end
    endtask

    // Pulse start for one edge, then wait (bounded) for done; lat counts edges after the capture edge.
    task automatic run(input string tag);
        int lat;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk({tag, "_busy_after_start"}, longint'(busy), 1);
        lat = 0;
        while (!done && lat < 100) begin
            tick(1);
            lat++;
        end
        chk({tag, "_latency"}, lat, 33);
        chk({tag, "_busy_at_done"}, longint'(busy), 0);
    endtask

    initial begin
        int zero[N];
        int imp_x[N], imp_re[N];
        int dc_x[N], dc_re[N];
        int alt_x[N], alt_re[N];
        int cos_x[N];
        int ndone, lat;
        zero   = '{default: 0};
        imp_x  = '{0: 100, default: 0};
        imp_re = '{default: 100};
        dc_x   = '{default: 5};
        dc_re  = '{0: 80, default: 0};
        for (int i = 0; i < N; i++) alt_x[i] = (i % 2 == 0) ? 10 : -10;
        alt_re = '{8: 160, default: 0};
        cos_x  = '{100, 92, 71, 38, 0, -38, -71, -92, -100, -92, -71, -38, 0, 38, 71, 92};

        // Reset held with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        load(imp_x);
        tick(2);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        check_bins("rst", zero, zero);
        start = 1'b0;
        rst_n = 1'b1;
        tick(1);
        chk("idle_no_start_busy", longint'(busy), 0);

        // Impulse
        load(imp_x);
        run("imp");
        check_bins("imp", imp_re, zero);
        tick(1);
        chk("imp_done_one_cycle", longint'(done), 0);

        // Reset in the middle of a transform
        load(dc_x);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_done", longint'(done), 0);
        check_bins("midrst", zero, zero);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);

        // DC
        load(dc_x);
        run("dc");
        check_bins("dc", dc_re, zero);

        // Alternating
        load(alt_x);
        run("alt");
        check_bins("alt", alt_re, zero);

        // Cosine at bin 1
        load(cos_x);
        run("cos");
        for (int k = 0; k < N; k++) begin
            if (k == 1 || k == 15)
                chk_rng($sformatf("cos_re%0d", k), bin_re(k), 784, 816);
            else
                chk_rng($sformatf("cos_re%0d", k), bin_re(k), -16, 16);
            chk_rng($sformatf("cos_im%0d", k), bin_im(k), -16, 16);
        end

        // Second start while busy must be ignored
        load(dc_x);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            if (done) ndone++;
        end
        chk("hs_single_done", ndone, 1);
        check_bins("hs", dc_re, zero);

        // New transform: outputs hold old result until the next done
        load(alt_x);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        load(imp_x);
        tick(20);
        chk("hold_re0", bin_re(0), 80);
        chk("hold_re8", bin_re(8), 0);
        chk("hold_busy", longint'(busy), 1);
        lat = 20;
        while (!done && lat < 100) begin
            tick(1);
            lat++;
        end
        chk("hs2_latency", lat, 33);
        check_bins("hs2", alt_re, zero);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
